// File: rtl/tlk2711_tx_if.sv
// Parallel-side bundle of the TLK2711 transmit framer: frame request, payload stream, status and line outputs.
interface tlk2711_tx_if #(
  parameter int LEN_W = 16
);
  logic             i_start;
  logic [LEN_W-1:0] i_len;
  logic [15:0]      i_data;
  logic             i_data_valid;
  logic             o_data_ready;
  logic             o_busy;
  logic             o_done;
  logic             o_underflow;
  logic [15:0]      o_txd;
  logic             o_tkmsb;
  logic             o_tklsb;

  modport master (
    output i_start, i_len, i_data, i_data_valid,
    input  o_data_ready, o_busy, o_done, o_underflow, o_txd, o_tkmsb, o_tklsb
  );

  modport slave (
    input  i_start, i_len, i_data, i_data_valid,
    output o_data_ready, o_busy, o_done, o_underflow, o_txd, o_tkmsb, o_tklsb
  );
endinterface

// File: rtl/tlk2711_tx.sv
// TLK2711 transmit framer: SP idle, sync preamble, SF, payload, EF, gap; line outputs registered (1 cycle).
// Payload is never stalled: o_data_ready is high for every DATA_s slot and a missing word becomes 0000 + underflow.
module tlk2711_tx #(
  parameter int SYNC_LEN = 4,
  parameter int GAP_LEN  = 2,
  parameter int LEN_W    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  tlk2711_tx_if.slave bus
);

  localparam logic [15:0] SP_WORD = 16'hC5BC;
  localparam logic [15:0] SF_WORD = 16'h5CFB;
  localparam logic [15:0] EF_WORD = 16'hFDFE;
  localparam logic [7:0]  SYNC_INIT = 8'(SYNC_LEN);
  localparam logic [7:0]  GAP_INIT  = 8'(GAP_LEN);

  typedef enum logic [2:0] {
    IDLE_s,
    SYNC_s,
    SOF_s,
    DATA_s,
    EOF_s,
    GAP_s
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [7:0]       sync_q, sync_d;
  logic [7:0]       gap_q, gap_d;
  logic [15:0]      txd_d;
  logic             tkmsb_d, tklsb_d;
  logic             done_d, underflow_d;

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    sync_d      = sync_q;
    gap_d       = gap_q;
    txd_d       = SP_WORD;
    tkmsb_d     = 1'b0;
    tklsb_d     = 1'b1;
    done_d      = 1'b0;
    underflow_d = 1'b0;

    case (state_q)
      IDLE_s: begin
        if (bus.i_start) begin
          rem_d   = bus.i_len;
          sync_d  = SYNC_INIT;
          state_d = SYNC_s;
        end
      end
      SYNC_s: begin
        sync_d = sync_q - 8'd1;
        if (sync_q <= 8'd1) state_d = SOF_s;
      end
      SOF_s: begin
        txd_d   = SF_WORD;
        tkmsb_d = 1'b1;
        state_d = (rem_q != '0) ? DATA_s : EOF_s;
      end
      DATA_s: begin
        tkmsb_d = 1'b0;
        tklsb_d = 1'b0;
        // The slot is consumed whether or not a word arrived, so frame length stays fixed.
        if (bus.i_data_valid) begin
          txd_d = bus.i_data;
        end else begin
          txd_d       = 16'h0000;
          underflow_d = 1'b1;
        end
        rem_d = rem_q - 1'b1;
        if (rem_q == LEN_W'(1)) state_d = EOF_s;
      end
      EOF_s: begin
        txd_d   = EF_WORD;
        tkmsb_d = 1'b1;
        done_d  = 1'b1;
        gap_d   = GAP_INIT;
        state_d = GAP_s;
      end
      GAP_s: begin
        gap_d = gap_q - 8'd1;
        if (gap_q <= 8'd1) state_d = IDLE_s;
      end
      default: state_d = IDLE_s;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE_s;
      rem_q           <= '0;
      sync_q          <= '0;
      gap_q           <= '0;
      bus.o_txd       <= SP_WORD;
      bus.o_tkmsb     <= 1'b0;
      bus.o_tklsb     <= 1'b1;
      bus.o_done      <= 1'b0;
      bus.o_underflow <= 1'b0;
    end else begin
      state_q         <= state_d;
      rem_q           <= rem_d;
      sync_q          <= sync_d;
      gap_q           <= gap_d;
      bus.o_txd       <= txd_d;
      bus.o_tkmsb     <= tkmsb_d;
      bus.o_tklsb     <= tklsb_d;
      bus.o_done      <= done_d;
      bus.o_underflow <= underflow_d;
    end
  end

  assign bus.o_data_ready = (state_q == DATA_s);
  assign bus.o_busy       = (state_q != IDLE_s);

endmodule

// File: tb/tb_tlk2711_tx.sv
// Bench for tlk2711_tx: directed vector table, corner-case frames and random traffic against a frame-position model.
module tb_tlk2711_tx;

  localparam int SYNC_LEN = 4;
  localparam int GAP_LEN  = 2;
  localparam int LEN_W    = 16;
  localparam logic [15:0] SP = 16'hC5BC;
  localparam logic [15:0] SF = 16'h5CFB;
  localparam logic [15:0] EF = 16'hFDFE;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tlk2711_tx_if #(.LEN_W(LEN_W)) ifc ();

  tlk2711_tx #(.SYNC_LEN(SYNC_LEN), .GAP_LEN(GAP_LEN), .LEN_W(LEN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  int checks = 0;
  int errors = 0;

  // Model: position within the current frame (-1 = idle) and the latched length.
  int m_pos = -1;
  int m_len = 0;

  int hs_cnt, done_cnt, uf_cnt, data_cnt, rdy_cnt;

  typedef struct {
    bit          start;
    logic [15:0] len;
    logic [15:0] data;
    logic [15:0] e_txd;
    logic [1:0]  e_k;
    bit          e_rdy;
    bit          e_busy;
    bit          e_done;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(bit s, logic [15:0] l, logic [15:0] d, logic [15:0] t,
                              logic [1:0] k, bit r, bit b, bit dn);
    vec_t v;
    v.start = s; v.len = l; v.data = d; v.e_txd = t; v.e_k = k;
    v.e_rdy = r; v.e_busy = b; v.e_done = dn;
    return v;
  endfunction

  function automatic bit in_data(int p, int len);
    return (p > SYNC_LEN) && (p <= SYNC_LEN + len);
  endfunction

  // One clock: predict the line word from the frame position, advance, compare.
  task automatic tick();
    logic [15:0] e_txd;
    logic [1:0]  e_k;
    bit          e_done, e_uf;
    int          nxt, nlen, p, dlast;
    e_txd = SP; e_k = 2'b01; e_done = 0; e_uf = 0; nlen = m_len;
    if (m_pos < 0) begin
      nxt = ifc.i_start ? 0 : -1;
      if (ifc.i_start) nlen = int'(ifc.i_len);
    end else begin
      p = m_pos;
      dlast = SYNC_LEN + m_len;
      if (p == SYNC_LEN) begin
        e_txd = SF; e_k = 2'b11;
      end else if (in_data(p, m_len)) begin
        e_k = 2'b00;
        if (ifc.i_data_valid) e_txd = ifc.i_data;
        else begin e_txd = 16'h0000; e_uf = 1; end
      end else if (p == dlast + 1) begin
        e_txd = EF; e_k = 2'b11; e_done = 1;
      end
      nxt = (p == dlast + 1 + GAP_LEN) ? -1 : p + 1;
    end
    if (ifc.o_data_ready && ifc.i_data_valid) hs_cnt++;
    if (ifc.o_data_ready) rdy_cnt++;
    @(posedge clk);
    #1;
    m_pos = nxt;
    m_len = nlen;
    chk("txd", ifc.o_txd, e_txd);
    chk("k_flags", {ifc.o_tkmsb, ifc.o_tklsb}, e_k);
    chk("done", ifc.o_done, e_done);
    chk("underflow", ifc.o_underflow, e_uf);
    chk("busy", ifc.o_busy, m_pos >= 0);
    chk("ready", ifc.o_data_ready, in_data(m_pos, m_len));
    if (ifc.o_done) done_cnt++;
    if (ifc.o_underflow) uf_cnt++;
    if ({ifc.o_tkmsb, ifc.o_tklsb} == 2'b00) data_cnt++;
  endtask

  task automatic clr_counts();
    hs_cnt = 0; done_cnt = 0; uf_cnt = 0; data_cnt = 0; rdy_cnt = 0;
  endtask

  // Whole frame; bad_slot (1-based) has valid low, intr_len >= 0 re-requests during slot 1.
  task automatic run_frame(input int len, input int bad_slot, input int intr_len);
    int guard, slot, exp_uf;
    clr_counts();
    ifc.i_start = 1'b1;
    ifc.i_len = 16'(len);
    ifc.i_data_valid = 1'b1;
    tick();
    ifc.i_start = 1'b0;
    guard = 0;
    while (m_pos >= 0 && guard < 70000) begin
      slot = m_pos - SYNC_LEN;
      ifc.i_data_valid = in_data(m_pos, m_len) ? (slot != bad_slot) : 1'b1;
      ifc.i_data = 16'($urandom);
      if (intr_len >= 0 && slot == 1 && in_data(m_pos, m_len)) begin
        ifc.i_start = 1'b1;
        ifc.i_len = 16'(intr_len);
      end else begin
        ifc.i_start = 1'b0;
      end
      tick();
      guard++;
    end
    ifc.i_start = 1'b0;
    chk("frame_timeout", guard >= 70000, 0);
    exp_uf = (bad_slot >= 1 && bad_slot <= len) ? 1 : 0;
    chk("done_pulses", done_cnt, 1);
    chk("underflow_pulses", uf_cnt, exp_uf);
    chk("data_slots", data_cnt, len);
    chk("handshakes", hs_cnt, len - exp_uf);
    chk("ready_cycles", rdy_cnt, len);
    repeat (3) tick();
    chk("idle_after_frame", ifc.o_busy, 0);
  endtask

  initial begin
    int guard;
    ifc.i_start = 0;
    ifc.i_len = '0;
    ifc.i_data = '0;
    ifc.i_data_valid = 0;
    clr_counts();

    // Reset state
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("rst_txd", ifc.o_txd, SP);
      chk("rst_k", {ifc.o_tkmsb, ifc.o_tklsb}, 2'b01);
      chk("rst_busy", ifc.o_busy, 0);
      chk("rst_ready", ifc.o_data_ready, 0);
      chk("rst_done", ifc.o_done, 0);
      chk("rst_uf", ifc.o_underflow, 0);
    end
    rst_n = 1'b1;
    m_pos = -1;
    repeat (5) tick();

    // Directed frame of 3 words, then a request during the gap that must be ignored
    tbl[0]  = mk(1, 16'd3, 16'hBEEF, SP, 2'b01, 0, 1, 0);
    tbl[1]  = mk(0, 16'd3, 16'hBEEF, SP, 2'b01, 0, 1, 0);
    tbl[2]  = mk(0, 16'd3, 16'hBEEF, SP, 2'b01, 0, 1, 0);
    tbl[3]  = mk(0, 16'd3, 16'hBEEF, SP, 2'b01, 0, 1, 0);
    tbl[4]  = mk(0, 16'd0, 16'hBEEF, SP, 2'b01, 0, 1, 0);
    tbl[5]  = mk(0, 16'd0, 16'hBEEF, SF, 2'b11, 1, 1, 0);
    tbl[6]  = mk(0, 16'd0, 16'hA001, 16'hA001, 2'b00, 1, 1, 0);
    tbl[7]  = mk(0, 16'd0, 16'hA002, 16'hA002, 2'b00, 1, 1, 0);
    tbl[8]  = mk(0, 16'd0, 16'hA003, 16'hA003, 2'b00, 0, 1, 0);
    tbl[9]  = mk(0, 16'd0, 16'hBEEF, EF, 2'b11, 0, 1, 1);
    tbl[10] = mk(1, 16'd7, 16'hBEEF, SP, 2'b01, 0, 1, 0);
    tbl[11] = mk(0, 16'd0, 16'hBEEF, SP, 2'b01, 0, 0, 0);
    clr_counts();
    for (int i = 0; i < 12; i++) begin
      ifc.i_start = tbl[i].start;
      ifc.i_len = tbl[i].len;
      ifc.i_data = tbl[i].data;
      ifc.i_data_valid = 1'b1;
      tick();
      chk($sformatf("vec%0d_txd", i), ifc.o_txd, tbl[i].e_txd);
      chk($sformatf("vec%0d_k", i), {ifc.o_tkmsb, ifc.o_tklsb}, tbl[i].e_k);
      chk($sformatf("vec%0d_ready", i), ifc.o_data_ready, tbl[i].e_rdy);
      chk($sformatf("vec%0d_busy", i), ifc.o_busy, tbl[i].e_busy);
      chk($sformatf("vec%0d_done", i), ifc.o_done, tbl[i].e_done);
    end
    ifc.i_start = 1'b0;
    chk("vec_handshakes", hs_cnt, 3);
    chk("vec_done_pulses", done_cnt, 1);
    repeat (2) tick();

    // Zero-length frame, underflow in slot 2, ignored re-request mid-payload
    run_frame(0, -1, -1);
    run_frame(4, 2, -1);
    run_frame(6, -1, 9);

    // Reset while payload word 2 of 5 is being driven
    ifc.i_start = 1'b1;
    ifc.i_len = 16'd5;
    ifc.i_data_valid = 1'b1;
    tick();
    ifc.i_start = 1'b0;
    guard = 0;
    while (m_pos != SYNC_LEN + 2 && guard < 50) begin
      ifc.i_data = 16'($urandom);
      tick();
      guard++;
    end
    chk("reach_word2", guard >= 50, 0);
    #2;
    rst_n = 1'b0;
    #1;
    m_pos = -1;
    chk("midrst_txd", ifc.o_txd, SP);
    chk("midrst_k", {ifc.o_tkmsb, ifc.o_tklsb}, 2'b01);
    chk("midrst_busy", ifc.o_busy, 0);
    chk("midrst_ready", ifc.o_data_ready, 0);
    chk("midrst_done", ifc.o_done, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_hold_txd", ifc.o_txd, SP);
    rst_n = 1'b1;
    tick();
    run_frame(1, -1, -1);

    // Maximum length: counter must not wrap
    run_frame(65535, -1, -1);

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      ifc.i_start = ($urandom_range(0, 3) == 0);
      ifc.i_len = 16'($urandom_range(0, 12));
      ifc.i_data_valid = ($urandom_range(0, 4) != 0);
      ifc.i_data = 16'($urandom);
      tick();
    end
    ifc.i_start = 1'b0;
    guard = 0;
    while (m_pos >= 0 && guard < 100) begin
      tick();
      guard++;
    end
    chk("drain_timeout", guard >= 100, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tlk2711_tx.md
Name: tlk2711_tx

Overview:
- Transmit-side framer for the TLK2711 SerDes parallel interface. Counterpart of the link receiver.
- Drives 16-bit TXD with the per-byte K-flags TKMSB and TKLSB.
- Between frames it emits the idle/sync pattern SP. On request it sends a sync preamble, SF, a caller-specified number of payload words from a valid/ready stream, EF, and a minimum inter-frame gap.

Parameters:
- SYNC_LEN, 4: number of SP words sent before SF (range 1..255).
- GAP_LEN, 2: minimum SP words after EF before a new frame may start (range 1..255).
- LEN_W, 16: width of the frame length field.

Ports:
- clk  in  1  core clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_start  in  1  frame request; sampled only in IDLE_s.
- i_len  in  LEN_W  payload length in 16-bit words; latched when i_start is accepted.
- i_data  in  16  payload word.
- i_data_valid  in  1  payload word valid.
- o_data_ready  out  1  payload word accepted when i_data_valid & o_data_ready.
- o_busy  out  1  high in every state except IDLE_s.
- o_done  out  1  one-cycle pulse when EF is driven.
- o_underflow  out  1  one-cycle pulse when a payload slot had no valid data.
- o_txd  out  16  TLK2711 TXD.
- o_tkmsb  out  1  K-flag for o_txd[15:8].
- o_tklsb  out  1  K-flag for o_txd[7:0].

Behaviour:
- Code words, as {txd, tkmsb, tklsb}:
  - SP = 16'hC5BC, 0, 1
  - SF = 16'h5CFB, 1, 1
  - EF = 16'hFDFE, 1, 1
  - data = word, 0, 0
- All TLK outputs are registered. The word selected by the state in cycle n appears on o_txd in cycle n+1.
- Reset (async assert, sync deassert is the integrator's job):
  - state = IDLE_s.
  - o_txd = 16'hC5BC, o_tkmsb = 0, o_tklsb = 1.
  - o_data_ready, o_busy, o_done, o_underflow = 0.
  - Counters = 0.
- States and transitions:
  - IDLE_s: drive SP. If i_start, latch i_len into rem_cnt, load sync_cnt = SYNC_LEN, go to SYNC_s.
  - SYNC_s: drive SP and decrement sync_cnt. When sync_cnt reaches 1, go to SOF_s. Exactly SYNC_LEN SP words are sent after acceptance.
  - SOF_s: drive SF for one cycle. Go to DATA_s if rem_cnt != 0, else EOF_s.
  - DATA_s:
    - o_data_ready = 1 (combinational from state).
    - If i_data_valid, drive i_data.
    - If not valid, drive 16'h0000 with K = 00 and pulse o_underflow. The slot still counts.
    - Decrement rem_cnt every cycle. When rem_cnt == 1, go to EOF_s. Exactly i_len data slots are sent.
  - EOF_s: drive EF, pulse o_done, load gap_cnt = GAP_LEN, go to GAP_s.
  - GAP_s: drive SP and decrement gap_cnt. At 1, go to IDLE_s.
- Data is never stalled: the frame length on the line is fixed at SYNC_LEN + 1 + i_len + 1 words. A K character never appears inside the payload.
- i_start outside IDLE_s is ignored; no queuing. i_len changes after acceptance have no effect.
- i_len = 0: SF is followed immediately by EF.
- i_len = 2^LEN_W - 1 must work; the counter must not wrap.
- Reset asserted mid-frame: outputs return to SP immediately (asynchronously). No EF is sent and o_done is not pulsed.
- o_data_ready is 0 in every state except DATA_s.

Test Plan:
- Reset held, then released with no i_start: o_txd = C5BC, tkmsb = 0, tklsb = 1 every cycle; o_busy = 0.
- i_start with i_len = 3, data A001, A002, A003 always valid, SYNC_LEN = 4, GAP_LEN = 2:
  - Line sequence SP×4, SF(5CFB, 11), A001, A002, A003 (K = 00), EF(FDFE, 11), SP×2.
  - o_done pulses once, with EF.
  - Exactly 3 ready&valid handshakes.
  - Next i_start accepted only after the 2 gap words.
- i_len = 0: SP×4, SF, EF, SP×2; o_data_ready never asserted.
- i_len = 4 with i_data_valid low in the 2nd slot:
  - 2nd slot is 0000/00; o_underflow pulses once.
  - Total 4 data slots, then EF.
- i_start pulsed during DATA_s with a different i_len: ignored; current frame length unchanged; no second frame.
- rst_n asserted while sending payload word 2 of 5: o_txd = C5BC/01 immediately, o_busy = 0; after release, a new i_len = 1 frame is sent correctly.
